spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave_pkg.sv | 11 +
 rtl/spi_sync_edge.sv | 26 ++
 rtl/spi_slave.sv | 118 +++++++++++
 tb/tb_spi_slave.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_pkg.sv
// spi_slave_pkg: shared FSM states, SPI mode decode and idle TX fill for the SPI slave
package spi_slave_pkg;
  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
  localparam logic [7:0] TX_FILL = 8'hFF;
  function automatic logic mode_cpol(input int mode);
    return (mode == 2) || (mode == 3);
  endfunction
  function automatic logic mode_cpha(input int mode);
    return (mode == 1) || (mode == 3);
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-flop synchronizer with one-cycle rise/fall pulses on the synchronized value
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Async,
  output logic o_Sync,
  output logic o_Rise,
  output logic o_Fall
);
  logic r_Meta, r_Sync, r_Prev;
  always_ff @(posedge i_Clk)
    if (i_Rst) begin
      r_Meta <= RST_VAL;
      r_Sync <= RST_VAL;
      r_Prev <= RST_VAL;
    end else begin
      r_Meta <= i_Async;
      r_Sync <= r_Meta;
      r_Prev <= r_Sync;
    end
  assign o_Sync = r_Sync;
  assign o_Rise = r_Sync & ~r_Prev;
  assign o_Fall = ~r_Sync & r_Prev;
endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI slave (modes 0-3) oversampled on i_Clk, with a one-byte pending TX buffer
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int SPI_MODE = 0
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Ready,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_MOSI,
  input  logic       i_SPI_CS_n,
  output logic       o_SPI_MISO,
  output logic       o_SPI_MISO_En
);
  localparam logic CPOL = mode_cpol(SPI_MODE);
  localparam logic CPHA = mode_cpha(SPI_MODE);
  logic w_Sclk, w_Sclk_Rise, w_Sclk_Fall;
  logic w_Mosi, w_Mosi_Rise, w_Mosi_Fall;
  logic w_Cs_n, w_Cs_Rise, w_Cs_Fall;
  logic w_Lead, w_Trail, w_Active, w_Sample, w_Shift, w_Byte_Done, w_Load, w_unused;
  logic [7:0] w_Load_Byte;
  logic [2:0] w_Tx_Idx;
  state_t r_State;
  logic [2:0] r_Rx_Cnt, r_Tx_Cnt;
  logic [7:0] r_Rx_Shift, r_Rx_Byte, r_Tx_Shift, r_Pending;
  logic r_Rx_DV, r_Pending_Valid, r_Miso;

  spi_sync_edge #(.RST_VAL(CPOL)) u_sclk (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Async(i_SPI_Clk),
    .o_Sync(w_Sclk), .o_Rise(w_Sclk_Rise), .o_Fall(w_Sclk_Fall)
  );
  spi_sync_edge #(.RST_VAL(1'b0)) u_mosi (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Async(i_SPI_MOSI),
    .o_Sync(w_Mosi), .o_Rise(w_Mosi_Rise), .o_Fall(w_Mosi_Fall)
  );
  spi_sync_edge #(.RST_VAL(1'b1)) u_cs (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Async(i_SPI_CS_n),
    .o_Sync(w_Cs_n), .o_Rise(w_Cs_Rise), .o_Fall(w_Cs_Fall)
  );
  assign w_unused = ^{w_Sclk, w_Mosi_Rise, w_Mosi_Fall};

  assign w_Lead      = CPOL ? w_Sclk_Fall : w_Sclk_Rise;
  assign w_Trail     = CPOL ? w_Sclk_Rise : w_Sclk_Fall;
  assign w_Active    = (r_State == ACTIVE) && !w_Cs_Rise;
  assign w_Sample    = w_Active && (CPHA ? w_Trail : w_Lead);
  assign w_Shift     = w_Active && (CPHA ? w_Lead : w_Trail);
  assign w_Byte_Done = w_Sample && (r_Rx_Cnt == 3'd7);
  assign w_Load      = ((r_State == IDLE) && w_Cs_Fall) || w_Byte_Done;
  assign w_Load_Byte = r_Pending_Valid ? r_Pending : TX_FILL;
  // CPHA=0 already presented bit 7 at load, so shift edges start at bit 6
  assign w_Tx_Idx    = 3'd7 - r_Tx_Cnt - {2'b00, ~CPHA};

  always_ff @(posedge i_Clk)
    if (i_Rst) r_State <= IDLE;
    else if ((r_State == IDLE) && w_Cs_Fall) r_State <= ACTIVE;
    else if ((r_State == ACTIVE) && w_Cs_Rise) r_State <= IDLE;

  always_ff @(posedge i_Clk)
    if (i_Rst) begin
      r_Rx_Cnt   <= '0;
      r_Rx_Shift <= '0;
      r_Rx_Byte  <= '0;
      r_Rx_DV    <= 1'b0;
    end else begin
      r_Rx_DV <= w_Byte_Done;
      if (!w_Active) begin
        r_Rx_Cnt   <= '0;
        r_Rx_Shift <= '0;
      end else if (w_Sample) begin
        r_Rx_Cnt   <= r_Rx_Cnt + 3'd1;
        r_Rx_Shift <= {r_Rx_Shift[6:0], w_Mosi};
      end
      if (w_Byte_Done) r_Rx_Byte <= {r_Rx_Shift[6:0], w_Mosi};
    end

  always_ff @(posedge i_Clk)
    if (i_Rst) begin
      r_Pending       <= '0;
      r_Pending_Valid <= 1'b0;
    end else if (w_Load && r_Pending_Valid) begin
      r_Pending_Valid <= 1'b0;
    end else if (i_TX_DV && !r_Pending_Valid) begin
      r_Pending       <= i_TX_Byte;
      r_Pending_Valid <= 1'b1;
    end

  // a load and a shift come from opposite SCLK edges, so they never share a cycle
  always_ff @(posedge i_Clk)
    if (i_Rst) begin
      r_Tx_Shift <= '0;
      r_Tx_Cnt   <= '0;
      r_Miso     <= 1'b0;
    end else begin
      if (!w_Active) begin
        r_Tx_Shift <= '0;
        r_Tx_Cnt   <= '0;
        r_Miso     <= 1'b0;
      end else if (w_Shift) begin
        r_Tx_Cnt <= r_Tx_Cnt + 3'd1;
        if (CPHA || (r_Tx_Cnt != 3'd7)) r_Miso <= r_Tx_Shift[w_Tx_Idx];
      end
      if (w_Load) begin
        r_Tx_Shift <= w_Load_Byte;
        if (!CPHA) r_Miso <= w_Load_Byte[7];
      end
    end

  assign o_RX_DV       = r_Rx_DV;
  assign o_RX_Byte     = r_Rx_Byte;
  assign o_TX_Ready    = ~r_Pending_Valid;
  assign o_SPI_MISO    = r_Miso;
  assign o_SPI_MISO_En = ~w_Cs_n;
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed checks of spi_slave in all four SPI modes, one instance per mode
module tb_spi_slave;
  localparam int HALF = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sclk = 1'b0;
  logic mosi = 1'b0;
  logic [3:0] cs_n = 4'hF;
  logic [3:0] tx_dv = 4'h0;
  logic [7:0] tx_byte = 8'h00;
  logic [3:0] rx_dv, tx_ready, miso, miso_en;
  logic [3:0][7:0] rx_byte;
  logic [7:0] got [3];
  logic [7:0] r;
  logic [7:0] rx_q [$];
  int cur = 0;
  int n_tot = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave #(.SPI_MODE(g)) dut (
      .i_Clk(clk), .i_Rst(rst),
      .o_RX_DV(rx_dv[g]), .o_RX_Byte(rx_byte[g]),
      .i_TX_DV(tx_dv[g]), .i_TX_Byte(tx_byte), .o_TX_Ready(tx_ready[g]),
      .i_SPI_Clk(sclk), .i_SPI_MOSI(mosi), .i_SPI_CS_n(cs_n[g]),
      .o_SPI_MISO(miso[g]), .o_SPI_MISO_En(miso_en[g])
    );
  end

  always @(negedge clk) if (rx_dv[cur]) rx_q.push_back(rx_byte[cur]);

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] pop_rx();
    if (rx_q.size() == 0) return 8'hxx;
    return rx_q.pop_front();
  endfunction

  task automatic set_mode(input int m);
    cur = m;
    sclk = (m >= 2);
    tick(4);
    rx_q.delete();
  endtask

  task automatic load_tx(input logic [7:0] b);
    tx_byte = b;
    tx_dv[cur] = 1'b1;
    tick(1);
    tx_dv = 4'h0;
  endtask

  task automatic feed(input logic [7:0] b);
    int t = 0;
    while (!tx_ready[cur] && t < 400) begin
      tick(1);
      t++;
    end
    chk("feed_ready", 32'(tx_ready[cur]), 32'd1);
    load_tx(b);
  endtask

  task automatic spi_begin();
    cs_n[cur] = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] d, input int nbits, output logic [7:0] q);
    logic cpol, cpha;
    cpol = (cur >= 2);
    cpha = (cur == 1) || (cur == 3);
    q = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!cpha) mosi = d[i];
      tick(HALF);
      if (cpha) mosi = d[i];
      else q[i] = miso[cur];
      sclk = ~cpol;
      tick(HALF);
      if (cpha) q[i] = miso[cur];
      sclk = cpol;
    end
  endtask

  task automatic spi_end();
    tick(HALF);
    cs_n[cur] = 1'b1;
    tick(3 * HALF);
  endtask

  task automatic xfer(input logic [7:0] d, output logic [7:0] q);
    spi_begin();
    spi_byte(d, 8, q);
    spi_end();
  endtask

  initial begin
    tick(3);
    chk("rst_rx_dv", 32'(rx_dv), 32'h0);
    chk("rst_rx_byte", 32'(rx_byte), 32'h0);
    chk("rst_tx_ready", 32'(tx_ready), 32'hF);
    chk("rst_miso", 32'(miso), 32'h0);
    chk("rst_miso_en", 32'(miso_en), 32'h0);
    rst = 1'b0;
    tick(2);

    for (int m = 0; m < 4; m++) begin
      set_mode(m);
      load_tx(m == 0 ? 8'hA5 : 8'h5A);
      chk("pre_ready", 32'(tx_ready[cur]), 32'd0);
      xfer(m == 0 ? 8'h3C : 8'hC3, r);
      chk($sformatf("m%0d_rx_cnt", m), rx_q.size(), 32'd1);
      chk($sformatf("m%0d_rx", m), 32'(pop_rx()), m == 0 ? 32'h3C : 32'hC3);
      chk($sformatf("m%0d_tx", m), 32'(r), m == 0 ? 32'hA5 : 32'h5A);
      chk($sformatf("m%0d_ready", m), 32'(tx_ready[cur]), 32'd1);
      chk($sformatf("m%0d_idle", m), {30'd0, miso[cur], miso_en[cur]}, 32'd0);
    end

    set_mode(0);
    load_tx(8'h11);
    fork
      begin
        spi_begin();
        spi_byte(8'hB1, 8, got[0]);
        spi_byte(8'hB2, 8, got[1]);
        spi_byte(8'hB3, 8, got[2]);
        spi_end();
      end
      begin
        feed(8'h22);
        feed(8'h33);
      end
    join
    chk("burst_rx_cnt", rx_q.size(), 32'd3);
    chk("burst_rx0", 32'(pop_rx()), 32'hB1);
    chk("burst_rx1", 32'(pop_rx()), 32'hB2);
    chk("burst_rx2", 32'(pop_rx()), 32'hB3);
    chk("burst_tx", {8'h0, got[0], got[1], got[2]}, 32'h112233);

    set_mode(3);
    load_tx(8'h44);
    fork
      begin
        spi_begin();
        spi_byte(8'hD1, 8, got[0]);
        spi_byte(8'hD2, 8, got[1]);
        spi_byte(8'hD3, 8, got[2]);
        spi_end();
      end
      feed(8'h55);
    join
    chk("fill_rx_cnt", rx_q.size(), 32'd3);
    chk("fill_rx2", {8'h0, pop_rx(), pop_rx(), pop_rx()}, 32'hD1D2D3);
    chk("fill_tx", {8'h0, got[0], got[1], got[2]}, 32'h4455FF);

    set_mode(1);
    spi_begin();
    spi_byte(8'hF0, 3, r);
    load_tx(8'h6D);
    spi_byte(8'hF0, 2, r);
    chk("abort_miso_en", 32'(miso_en[cur]), 32'd1);
    spi_end();
    chk("abort_no_rx", rx_q.size(), 32'd0);
    chk("abort_pending", 32'(tx_ready[cur]), 32'd0);
    xfer(8'h81, r);
    chk("after_abort_rx", 32'(pop_rx()), 32'h81);
    chk("after_abort_tx", 32'(r), 32'h6D);

    set_mode(2);
    load_tx(8'h3E);
    load_tx(8'h77);
    xfer(8'h96, r);
    chk("ignore_tx", 32'(r), 32'h3E);
    chk("ignore_rx", 32'(pop_rx()), 32'h96);
    chk("ignore_ready", 32'(tx_ready[cur]), 32'd1);

    set_mode(3);
    spi_begin();
    spi_byte(8'hFF, 2, r);
    load_tx(8'h4C);
    spi_byte(8'hFF, 2, r);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("mid_rst_rx_dv", 32'(rx_dv[cur]), 32'd0);
    chk("mid_rst_rx_byte", 32'(rx_byte[cur]), 32'h0);
    chk("mid_rst_ready", 32'(tx_ready[cur]), 32'd1);
    chk("mid_rst_miso", {30'd0, miso[cur], miso_en[cur]}, 32'd0);
    spi_end();
    chk("mid_rst_no_rx", rx_q.size(), 32'd0);
    load_tx(8'hE7);
    xfer(8'h5C, r);
    chk("post_rst_rx", 32'(pop_rx()), 32'h5C);
    chk("post_rst_tx", 32'(r), 32'hE7);
    chk("post_rst_cnt", rx_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
